// File: rtl/seq_detect2_if.sv
// Symbol stream, pattern and result bundle for the sequence detector.
// The master drives symbols and the pattern; the slave (detector) returns results.
interface seq_detect2_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    logic                 sym_valid;
    logic [1:0]           sym;
    logic [2*DEPTH-1:0]   pattern;
    logic                 clear;
    logic                 match;
    logic [CNT_W-1:0]     match_count;
    logic                 filled;

    modport master (
        output sym_valid, sym, pattern, clear,
        input  match, match_count, filled
    );

    modport slave (
        input  sym_valid, sym, pattern, clear,
        output match, match_count, filled
    );
endinterface

// File: rtl/seq_detect2.sv
// Sliding-window detector for a programmable sequence of 2-bit symbols.
// Overlapping occurrences are detected; matches are counted with saturation.
module seq_detect2 #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_detect2_if.slave  bus
);
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic {
        FILL,
        RUN
    } state_t;

    state_t             state_reg, state_next;
    logic [1:0]         window_reg  [DEPTH];
    logic [1:0]         window_next [DEPTH];
    logic [1:0]         window_shift [DEPTH];
    logic [FILL_W-1:0]  fill_reg, fill_next;
    logic               match_reg, match_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [DEPTH-1:0]   eq_vec;

    // Window as it would look after accepting the current symbol; the
    // compare runs on this so a match is flagged on the accepting edge.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            if (gi == DEPTH - 1) begin : g_newest
                assign window_shift[gi] = bus.sym;
            end else begin : g_older
                assign window_shift[gi] = window_reg[gi+1];
            end
            assign eq_vec[gi] = (window_shift[gi] == bus.pattern[2*gi +: 2]);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        fill_next  = fill_reg;
        match_next = 1'b0;
        count_next = count_reg;
        for (int i = 0; i < DEPTH; i++) begin
            window_next[i] = window_reg[i];
        end

        if (bus.clear) begin
            state_next = FILL;
            fill_next  = '0;
            count_next = '0;
            for (int i = 0; i < DEPTH; i++) begin
                window_next[i] = 2'b00;
            end
        end else if (bus.sym_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                window_next[i] = window_shift[i];
            end
            fill_next = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + 1'b1;
            case (state_reg)
                FILL:    state_next = (fill_next == FILL_FULL) ? RUN : FILL;
                RUN:     state_next = RUN;
                default: state_next = FILL;
            endcase
            // fill gates the compare so reset contents never match early
            match_next = (fill_next == FILL_FULL) && (&eq_vec);
            if (match_next && (count_reg != CNT_MAX)) begin
                count_next = count_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= FILL;
            fill_reg  <= '0;
            match_reg <= 1'b0;
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                window_reg[i] <= 2'b00;
            end
        end else begin
            state_reg <= state_next;
            fill_reg  <= fill_next;
            match_reg <= match_next;
            count_reg <= count_next;
            for (int i = 0; i < DEPTH; i++) begin
                window_reg[i] <= window_next[i];
            end
        end
    end

    assign bus.match       = match_reg;
    assign bus.match_count = count_reg;
    assign bus.filled      = (state_reg == RUN);
endmodule
